clk_div_prog: RTL and testbench

//  Multi-channel, runtime-programmable integer clock divider for the MAC datapath.

---
 rtl/clk_div_prog.sv | 123 ++++++++++++
 tb/tb_clk_div_prog.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable integer clock divider. Each channel emits a
// registered near-50% square wave, a period-end strobe and a pending-load flag.
module clk_div_prog #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic                    clk_i,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       pend_o
);

    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RST);

    // ceil(d/2) without widening: the high phase length of a period of d cycles
    function automatic logic [CNT_W-1:0] half_ceil(input logic [CNT_W-1:0] d);
        return (d >> 1) + {{(CNT_W-1){1'b0}}, d[0]};
    endfunction

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_r;
    logic [NUM_CH-1:0][CNT_W-1:0] div_r;
    logic [NUM_CH-1:0][CNT_W-1:0] pdiv_r;
    logic [NUM_CH-1:0]            pend_r;
    logic [NUM_CH-1:0]            run_r;
    logic [NUM_CH-1:0]            clk_r;
    logic [NUM_CH-1:0]            tick_r;

    logic [NUM_CH-1:0][CNT_W-1:0] div_in_s;
    logic [NUM_CH-1:0][CNT_W-1:0] div_n_s;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_n_s;
    logic [NUM_CH-1:0]            wrap_s;
    logic [NUM_CH-1:0]            bound_s;
    logic [NUM_CH-1:0]            apply_s;

    // Next-state decode per channel. run_r is low on the first enabled edge after
    // a disable or reset; that edge starts a fresh period at cnt 0 and counts as a
    // period boundary, so clk_o is high from the enabling edge onward.
    always_comb begin
        div_in_s = '0;
        div_n_s  = '0;
        cnt_n_s  = '0;
        wrap_s   = '0;
        bound_s  = '0;
        apply_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (div_i[c*CNT_W +: CNT_W] == ZERO_C) begin
                div_in_s[c] = ONE_C;
            end else begin
                div_in_s[c] = div_i[c*CNT_W +: CNT_W];
            end

            wrap_s[c]  = run_r[c] & (cnt_r[c] == (div_r[c] - ONE_C));
            bound_s[c] = ~en_i[c] | ~run_r[c] | wrap_s[c];
            apply_s[c] = bound_s[c] & (load_i[c] | pend_r[c]);

            // A load on the boundary edge itself beats an older pending value
            if (apply_s[c]) begin
                if (load_i[c]) begin
                    div_n_s[c] = div_in_s[c];
                end else begin
                    div_n_s[c] = pdiv_r[c];
                end
            end else begin
                div_n_s[c] = div_r[c];
            end

            if (run_r[c] && !wrap_s[c]) begin
                cnt_n_s[c] = cnt_r[c] + ONE_C;
            end else begin
                cnt_n_s[c] = ZERO_C;
            end
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt_r  <= '0;
            div_r  <= {NUM_CH{DIV_RST_C}};
            pdiv_r <= '0;
            pend_r <= '0;
            run_r  <= '0;
            clk_r  <= '0;
            tick_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (apply_s[c]) begin
                    div_r[c]  <= div_n_s[c];
                    pend_r[c] <= 1'b0;
                end else if (load_i[c]) begin
                    pdiv_r[c] <= div_in_s[c];
                    pend_r[c] <= 1'b1;
                end else begin
                    pend_r[c] <= pend_r[c];
                end

                if (en_i[c]) begin
                    cnt_r[c]  <= cnt_n_s[c];
                    run_r[c]  <= 1'b1;
                    clk_r[c]  <= (cnt_n_s[c] < half_ceil(div_n_s[c]));
                    tick_r[c] <= (cnt_n_s[c] == (div_n_s[c] - ONE_C));
                end else begin
                    cnt_r[c]  <= ZERO_C;
                    run_r[c]  <= 1'b0;
                    clk_r[c]  <= 1'b0;
                    tick_r[c] <= 1'b0;
                end
            end
        end
    end

    assign clk_o  = clk_r;
    assign tick_o = tick_r;
    assign pend_o = pend_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: directed vectors push hand-computed outputs,
// a monitor pops one expectation per clock edge and compares.
module tb_clk_div_prog;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic                    clk_i = 1'b0;
    logic                    rst   = 1'b1;
    logic [NUM_CH-1:0]       en_i  = '0;
    logic [NUM_CH-1:0]       load_i = '0;
    logic [NUM_CH*CNT_W-1:0] div_i = '0;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       pend_o;

    clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(2)) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .en_i  (en_i),
        .load_i(load_i),
        .div_i (div_i),
        .clk_o (clk_o),
        .tick_o(tick_o),
        .pend_o(pend_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] clk;
        logic [1:0] tick;
        logic [1:0] pend;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    // Reference model state (test 6)
    int m_cnt[NUM_CH], m_d[NUM_CH], m_p[NUM_CH];
    bit m_pend[NUM_CH], m_run[NUM_CH];

    // Monitor: one expectation belongs to each clock edge
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({clk_o, tick_o, pend_o} !== {e.clk, e.tick, e.pend}) begin
                    n_fail++;
                    $display("FAIL test%0d clk/tick/pend got %b/%b/%b expected %b/%b/%b at %0t",
                             e.tag, clk_o, tick_o, pend_o, e.clk, e.tick, e.pend, $time);
                end
            end
        end
    end

    // Directed step on channel 0 (channel 1 idle); exp0 = {clk, tick, pend}
    task automatic step(input logic r, input logic e0, input logic l0,
                        input logic [7:0] d0, input logic [2:0] exp0, input int tag);
        exp_t e;
        @(negedge clk_i);
        rst    = r;
        en_i   = {1'b0, e0};
        load_i = {1'b0, l0};
        div_i  = {8'd0, d0};
        e.clk  = {1'b0, exp0[2]};
        e.tick = {1'b0, exp0[1]};
        e.pend = {1'b0, exp0[0]};
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Model-checked step on both channels
    task automatic mstep(input logic r, input logic [1:0] en, input logic [1:0] ld,
                         input logic [15:0] dv, input int tag);
        exp_t e;
        int   nd;
        bit   start, wrap, bnd;
        e.clk = '0; e.tick = '0; e.pend = '0; e.tag = tag;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r) begin
                m_cnt[c] = 0; m_d[c] = 2; m_p[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            end else begin
                nd = int'(dv[c*8 +: 8]);
                if (nd == 0) nd = 1;
                start = !m_run[c];
                wrap  = m_run[c] && (m_cnt[c] == m_d[c] - 1);
                bnd   = !en[c] || start || wrap;
                if (bnd && (ld[c] || m_pend[c])) begin
                    m_d[c]    = ld[c] ? nd : m_p[c];
                    m_pend[c] = 0;
                end else if (ld[c]) begin
                    m_p[c]    = nd;
                    m_pend[c] = 1;
                end
                if (en[c]) begin
                    m_cnt[c]  = (start || wrap) ? 0 : m_cnt[c] + 1;
                    m_run[c]  = 1;
                    e.clk[c]  = (m_cnt[c] < (m_d[c] + 1) / 2);
                    e.tick[c] = (m_cnt[c] == m_d[c] - 1);
                end else begin
                    m_cnt[c] = 0;
                    m_run[c] = 0;
                end
                e.pend[c] = m_pend[c];
            end
        end
        @(negedge clk_i);
        rst    = r;
        en_i   = en;
        load_i = ld;
        div_i  = dv;
        exp_q.push_back(e);
    endtask

    initial begin
        // 1: reset overrides en, then default divide-by-2
        step(1'b1, 1'b1, 1'b0, 8'd0, 3'b000, 1);
        step(1'b1, 1'b1, 1'b0, 8'd0, 3'b000, 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 1);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 1);
        end
        // 2: divide by 3 and by 5, loaded while disabled
        step(1'b0, 1'b0, 1'b1, 8'd3, 3'b000, 2);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 2);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 2);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 2);
        end
        step(1'b0, 1'b0, 1'b1, 8'd5, 3'b000, 2);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 2);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 2);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 2);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 2);
            step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 2);
        end
        // 3: D=4 running, load 6 mid-period is deferred to the boundary
        step(1'b0, 1'b0, 1'b1, 8'd4, 3'b000, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 3);
        step(1'b0, 1'b1, 1'b1, 8'd6, 3'b001, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b011, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 3);
        // 4: loads on the wrap edge apply at once; div 0 and 1 both mean 1
        step(1'b0, 1'b1, 1'b1, 8'd2, 3'b100, 4);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 4);
        step(1'b0, 1'b1, 1'b1, 8'd0, 3'b110, 4);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b110, 4);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b110, 4);
        step(1'b0, 1'b1, 1'b1, 8'd1, 3'b110, 4);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b110, 4);
        // 5: drop en mid-period, restart cleanly, then reset with a load pending
        step(1'b0, 1'b1, 1'b1, 8'd5, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b0, 1'b0, 8'd0, 3'b000, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b000, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b1, 8'd7, 3'b101, 5);
        step(1'b1, 1'b1, 1'b0, 8'd0, 3'b000, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b010, 5);
        step(1'b0, 1'b1, 1'b0, 8'd0, 3'b100, 5);
        // 6: two independent channels, staggered, then random against the model
        mstep(1'b1, 2'b00, 2'b00, 16'h0000, 6);
        mstep(1'b0, 2'b00, 2'b01, 16'h0003, 6);
        mstep(1'b0, 2'b01, 2'b00, 16'h0000, 6);
        mstep(1'b0, 2'b01, 2'b10, 16'h0400, 6);
        mstep(1'b0, 2'b01, 2'b00, 16'h0000, 6);
        for (int i = 0; i < 14; i++) mstep(1'b0, 2'b11, 2'b00, 16'h0000, 6);
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  en, ld;
            logic [15:0] dv;
            en = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
            ld = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            dv = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
            mstep(($urandom_range(0, 99) == 0), en, ld, dv, 7);
        end

        @(posedge clk_i);
        #3;
        done = 1'b1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
